// File: rtl/alu_sequencer.sv
// ALU sequencer: IDLE/READ/EXEC/WB control around an external 16-bit ALU with a 16x16 register file.
// Define ALU_SEQ_IMM_EN to let instr_imm_sel select a sign-extended 8-bit immediate as operand B.
module alu_sequencer #(
    parameter logic [4:0] PSR_RST = 5'b00000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [3:0]  instr_op,
    input  logic [3:0]  instr_rdest,
    input  logic [3:0]  instr_rsrc,
    input  logic [7:0]  instr_imm,
    input  logic        instr_imm_sel,
    output logic [15:0] alu_rsrc,
    output logic [15:0] alu_rdest,
    output logic [3:0]  alu_opcode,
    input  logic [15:0] alu_out,
    input  logic [4:0]  alu_flags,
    input  logic        rf_wr_en,
    input  logic [3:0]  rf_wr_addr,
    input  logic [15:0] rf_wr_data,
    input  logic [3:0]  rf_rd_addr,
    output logic [15:0] rf_rd_data,
    output logic        done,
    output logic        err,
    output logic [4:0]  psr,
    output logic [15:0] wb_data
);
    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_CMP  = 4'd2;
    localparam logic [3:0] OP_LAST = 4'd9;

    state_t      state_q, state_d;
    logic        accept;
    logic [3:0]  op_q, rdest_q, rsrc_q;
    logic [15:0] rf_q [16];
    logic [15:0] opa_q, opb_q, opb_d;
    logic [3:0]  alu_op_q;
    logic [15:0] wb_data_q;
    logic [4:0]  flags_q, psr_q;
    logic        done_q, err_q;
    logic        op_illegal, rf_wb_en;

    assign instr_ready = (state_q == IDLE);
    assign accept      = instr_valid && instr_ready;
    assign op_illegal  = (alu_op_q > OP_LAST);
    assign rf_wb_en    = (state_q == WB) && !op_illegal && (alu_op_q != OP_CMP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = READ;
            READ:    state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            rdest_q <= '0;
            rsrc_q  <= '0;
        end else if (accept) begin
            op_q    <= instr_op;
            rdest_q <= instr_rdest;
            rsrc_q  <= instr_rsrc;
        end
    end

`ifdef ALU_SEQ_IMM_EN
    logic [7:0] imm_q;
    logic       imm_sel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imm_q     <= '0;
            imm_sel_q <= 1'b0;
        end else if (accept) begin
            imm_q     <= instr_imm;
            imm_sel_q <= instr_imm_sel;
        end
    end

    assign opb_d = imm_sel_q ? {{8{imm_q[7]}}, imm_q} : rf_q[rsrc_q];
`else
    logic unused_imm;
    assign unused_imm = ^{instr_imm, instr_imm_sel};
    assign opb_d      = rf_q[rsrc_q];
`endif

    // Operands are sampled at the READ edge, so host writes landing on that same edge are not seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_q     <= '0;
            opb_q     <= '0;
            alu_op_q  <= '0;
            wb_data_q <= '0;
            flags_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (state_q == READ) begin
                opa_q    <= rf_q[rdest_q];
                opb_q    <= opb_d;
                alu_op_q <= op_q;
            end
            if (state_q == EXEC) begin
                wb_data_q <= alu_out;
                flags_q   <= alu_flags;
            end
            done_q <= (state_q == EXEC);
            err_q  <= (state_q == EXEC) && op_illegal;
        end
    end

    // Writeback is assigned last so it overrides a host write to the same address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            if (rf_wr_en) begin
                rf_q[rf_wr_addr] <= rf_wr_data;
            end
            if (rf_wb_en) begin
                rf_q[rdest_q] <= wb_data_q;
            end
        end
    end

    // CMP refreshes only N, Z and L; carry (bit 0) and overflow (bit 2) survive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psr_q <= PSR_RST;
        end else if (state_q == WB) begin
            if (alu_op_q <= OP_SUB) begin
                psr_q <= flags_q;
            end else if (alu_op_q == OP_CMP) begin
                psr_q <= {flags_q[4], flags_q[3], psr_q[2], flags_q[1], psr_q[0]};
            end
        end
    end

    assign alu_rdest  = opa_q;
    assign alu_rsrc   = opb_q;
    assign alu_opcode = alu_op_q;
    assign rf_rd_data = rf_q[rf_rd_addr];
    assign done       = done_q;
    assign err        = err_q;
    assign psr        = psr_q;
    assign wb_data    = wb_data_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU model; expected values are hand-computed.
module tb_alu_sequencer;
    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  instr_op;
    logic [3:0]  instr_rdest;
    logic [3:0]  instr_rsrc;
    logic [7:0]  instr_imm;
    logic        instr_imm_sel;
    logic [15:0] alu_rsrc;
    logic [15:0] alu_rdest;
    logic [3:0]  alu_opcode;
    logic [15:0] alu_out;
    logic [4:0]  alu_flags;
    logic        rf_wr_en;
    logic [3:0]  rf_wr_addr;
    logic [15:0] rf_wr_data;
    logic [3:0]  rf_rd_addr;
    logic [15:0] rf_rd_data;
    logic        done;
    logic        err;
    logic [4:0]  psr;
    logic [15:0] wb_data;

    int n_checks = 0;
    int n_errors = 0;
    logic [16:0] alu_sum;

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rdest(instr_rdest), .instr_rsrc(instr_rsrc),
        .instr_imm(instr_imm), .instr_imm_sel(instr_imm_sel),
        .alu_rsrc(alu_rsrc), .alu_rdest(alu_rdest), .alu_opcode(alu_opcode),
        .alu_out(alu_out), .alu_flags(alu_flags),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .done(done), .err(err), .psr(psr), .wb_data(wb_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ALU model: flags {N,Z,F,L,C}; SUB/CMP carry is the carry-out of A + ~B + 1.
    always_comb begin
        alu_sum   = '0;
        alu_out   = '0;
        alu_flags = '0;
        case (alu_opcode)
            4'd0: begin
                alu_sum      = {1'b0, alu_rdest} + {1'b0, alu_rsrc};
                alu_out      = alu_sum[15:0];
                alu_flags[0] = alu_sum[16];
                alu_flags[2] = (alu_rdest[15] == alu_rsrc[15]) && (alu_sum[15] != alu_rdest[15]);
            end
            4'd1, 4'd2: begin
                alu_sum      = {1'b0, alu_rdest} + {1'b0, ~alu_rsrc} + 17'd1;
                alu_out      = alu_sum[15:0];
                alu_flags[0] = alu_sum[16];
                alu_flags[1] = (alu_rdest < alu_rsrc);
                alu_flags[2] = (alu_rdest[15] != alu_rsrc[15]) && (alu_sum[15] != alu_rdest[15]);
            end
            4'd3: begin alu_out = alu_rdest & alu_rsrc; alu_flags = 5'b10101; end
            4'd4: begin alu_out = alu_rdest | alu_rsrc; alu_flags = 5'b10101; end
            4'd5: begin alu_out = alu_rdest ^ alu_rsrc; alu_flags = 5'b10101; end
            4'd6: begin alu_out = ~alu_rdest;           alu_flags = 5'b10101; end
            4'd7: begin alu_out = alu_rsrc;             alu_flags = 5'b10101; end
            4'd8: begin alu_out = alu_rdest << 1;       alu_flags = 5'b10101; end
            4'd9: begin alu_out = alu_rdest >> 1;       alu_flags = 5'b10101; end
            default: begin alu_out = 16'hDEAD;          alu_flags = 5'b11111; end
        endcase
        if (alu_opcode <= 4'd2) begin
            alu_flags[3] = (alu_out == 16'h0000);
            alu_flags[4] = alu_out[15];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic host_write(input logic [3:0] addr, input logic [15:0] data);
        @(negedge clk);
        rf_wr_en   = 1'b1;
        rf_wr_addr = addr;
        rf_wr_data = data;
        @(posedge clk);
        #1;
        rf_wr_en = 1'b0;
    endtask

    task automatic check_rf(input string tag, input logic [3:0] addr, input logic [15:0] exp);
        rf_rd_addr = addr;
        #1;
        check_val(tag, rf_rd_data, exp);
    endtask

    // hw_phase: 0 = no host write, 1 = host write during READ, 2 = host write during WB.
    task automatic run_instr(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                             input logic [7:0] imm, input logic sel,
                             input int hw_phase, input logic [3:0] hw_addr, input logic [15:0] hw_data,
                             input logic exp_err, input logic [15:0] exp_a, input logic [15:0] exp_b);
        @(negedge clk);
        check_val("ready_idle", instr_ready, 1'b1);
        instr_valid   = 1'b1;
        instr_op      = op;
        instr_rdest   = rd;
        instr_rsrc    = rs;
        instr_imm     = imm;
        instr_imm_sel = sel;
        @(posedge clk);
        #1;
        check_val("ready_busy", instr_ready, 1'b0);
        check_val("done_read", done, 1'b0);
        instr_op      = ~op;
        instr_rdest   = ~rd;
        instr_rsrc    = ~rs;
        instr_imm     = ~imm;
        instr_imm_sel = ~sel;
        if (hw_phase == 1) begin
            rf_wr_en   = 1'b1;
            rf_wr_addr = hw_addr;
            rf_wr_data = hw_data;
        end
        @(posedge clk);
        #1;
        rf_wr_en = 1'b0;
        check_val("alu_rdest", alu_rdest, exp_a);
        check_val("alu_rsrc", alu_rsrc, exp_b);
        check_val("alu_opcode", alu_opcode, op);
        check_val("done_exec", done, 1'b0);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        check_val("done_wb", done, 1'b1);
        check_val("err_wb", err, exp_err);
        if (hw_phase == 2) begin
            rf_wr_en   = 1'b1;
            rf_wr_addr = hw_addr;
            rf_wr_data = hw_data;
        end
        @(posedge clk);
        #1;
        rf_wr_en = 1'b0;
        check_val("done_after", done, 1'b0);
        check_val("err_after", err, 1'b0);
        check_val("ready_after", instr_ready, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        instr_valid = 1'b0; instr_op = '0; instr_rdest = '0; instr_rsrc = '0;
        instr_imm = '0; instr_imm_sel = 1'b0;
        rf_wr_en = 1'b0; rf_wr_addr = '0; rf_wr_data = '0; rf_rd_addr = '0;
        #1;
        check_val("rst_ready", instr_ready, 1'b1);
        check_val("rst_psr", psr, 5'h00);
        check_val("rst_wb", wb_data, 16'h0000);
        check_val("rst_done", done, 1'b0);
        check_val("rst_err", err, 1'b0);
        check_val("rst_alu_a", alu_rdest, 16'h0000);
        check_val("rst_rf0", rf_rd_data, 16'h0000);
        #11;
        rst_n = 1'b1;

        // ADD 5 + 3
        host_write(4'd1, 16'h0005);
        host_write(4'd2, 16'h0003);
        run_instr(4'd0, 4'd1, 4'd2, 8'h00, 1'b0, 0, 4'd0, 16'h0, 1'b0, 16'h0005, 16'h0003);
        check_rf("add_rf1", 4'd1, 16'h0008);
        check_val("add_wb", wb_data, 16'h0008);
        check_val("add_psr", psr, 5'h00);

        // Host write during READ is not seen by the instruction
        host_write(4'd12, 16'h0100);
        host_write(4'd13, 16'h0020);
        run_instr(4'd0, 4'd12, 4'd13, 8'h00, 1'b0, 1, 4'd13, 16'h7000, 1'b0, 16'h0100, 16'h0020);
        check_rf("rdhide_rf12", 4'd12, 16'h0120);
        check_rf("rdhide_rf13", 4'd13, 16'h7000);

        // SUB 3 - 5
        host_write(4'd1, 16'h0003);
        host_write(4'd2, 16'h0005);
        run_instr(4'd1, 4'd1, 4'd2, 8'h00, 1'b0, 0, 4'd0, 16'h0, 1'b0, 16'h0003, 16'h0005);
        check_rf("sub_rf1", 4'd1, 16'hFFFE);
        check_val("sub_psr", psr, 5'h12);

        // CMP equal keeps C=0 from the SUB
        host_write(4'd3, 16'h1234);
        host_write(4'd4, 16'h1234);
        run_instr(4'd2, 4'd3, 4'd4, 8'h00, 1'b0, 0, 4'd0, 16'h0, 1'b0, 16'h1234, 16'h1234);
        check_val("cmp0_psr", psr, 5'h08);

        // ADD with carry out, then CMP keeps C=1
        host_write(4'd5, 16'hFFFF);
        host_write(4'd6, 16'h0002);
        run_instr(4'd0, 4'd5, 4'd6, 8'h00, 1'b0, 0, 4'd0, 16'h0, 1'b0, 16'hFFFF, 16'h0002);
        check_rf("addc_rf5", 4'd5, 16'h0001);
        check_val("addc_psr", psr, 5'h01);
        run_instr(4'd2, 4'd3, 4'd4, 8'h00, 1'b0, 0, 4'd0, 16'h0, 1'b0, 16'h1234, 16'h1234);
        check_val("cmp1_psr", psr, 5'h09);
        check_rf("cmp1_rf3", 4'd3, 16'h1234);

        // SUB with signed overflow, then CMP keeps C and F
        host_write(4'd7, 16'h8000);
        host_write(4'd8, 16'h0001);
        run_instr(4'd1, 4'd7, 4'd8, 8'h00, 1'b0, 0, 4'd0, 16'h0, 1'b0, 16'h8000, 16'h0001);
        check_rf("subv_rf7", 4'd7, 16'h7FFF);
        check_val("subv_psr", psr, 5'h05);
        run_instr(4'd2, 4'd3, 4'd4, 8'h00, 1'b0, 0, 4'd0, 16'h0, 1'b0, 16'h1234, 16'h1234);
        check_val("cmp2_psr", psr, 5'h0D);

        // Illegal opcode
        run_instr(4'hC, 4'd3, 4'd4, 8'h00, 1'b0, 0, 4'd0, 16'h0, 1'b1, 16'h1234, 16'h1234);
        check_rf("ill_rf3", 4'd3, 16'h1234);
        check_val("ill_psr", psr, 5'h0D);
        check_val("ill_wb", wb_data, 16'hDEAD);

        // AND leaves psr untouched
        run_instr(4'd3, 4'd7, 4'd8, 8'h00, 1'b0, 0, 4'd0, 16'h0, 1'b0, 16'h7FFF, 16'h0001);
        check_rf("and_rf7", 4'd7, 16'h0001);
        check_val("and_psr", psr, 5'h0D);

        // Writeback beats a same-address host write; a different address host write completes
        host_write(4'd9, 16'h2222);
        host_write(4'd10, 16'h1111);
        run_instr(4'd7, 4'd9, 4'd10, 8'h00, 1'b0, 2, 4'd9, 16'hBEEF, 1'b0, 16'h2222, 16'h1111);
        check_rf("prio_rf9", 4'd9, 16'h1111);
        run_instr(4'd7, 4'd9, 4'd10, 8'h00, 1'b0, 2, 4'd11, 16'h5A5A, 1'b0, 16'h1111, 16'h1111);
        check_rf("side_rf11", 4'd11, 16'h5A5A);
        check_rf("side_rf9", 4'd9, 16'h1111);

        host_write(4'd1, 16'h0010);
`ifdef ALU_SEQ_IMM_EN
        run_instr(4'd0, 4'd1, 4'd2, 8'hFE, 1'b1, 0, 4'd0, 16'h0, 1'b0, 16'h0010, 16'hFFFE);
        check_rf("imm_rf1", 4'd1, 16'h000E);
        check_val("imm_psr", psr, 5'h01);
`else
        host_write(4'd2, 16'hFFF0);
        run_instr(4'd0, 4'd1, 4'd2, 8'hFE, 1'b1, 0, 4'd0, 16'h0, 1'b0, 16'h0010, 16'hFFF0);
        check_rf("noimm_rf1", 4'd1, 16'h0000);
        check_val("noimm_psr", psr, 5'h09);
`endif

        // Reset asserted during EXEC
        @(negedge clk);
        instr_valid = 1'b1; instr_op = 4'd3; instr_rdest = 4'd9; instr_rsrc = 4'd10; instr_imm_sel = 1'b0;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        check_val("mid_alu_a", alu_rdest, 16'h1111);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_alu_a0", alu_rdest, 16'h0000);
        check_val("mid_alu_b0", alu_rsrc, 16'h0000);
        check_val("mid_op0", alu_opcode, 4'h0);
        check_val("mid_wb0", wb_data, 16'h0000);
        check_val("mid_psr0", psr, 5'h00);
        check_val("mid_ready", instr_ready, 1'b1);
        check_val("mid_done", done, 1'b0);
        rf_rd_addr = 4'd9;
        #1;
        check_val("mid_rf9", rf_rd_data, 16'h0000);
        @(posedge clk);
        #1;
        check_val("mid_done2", done, 1'b0);
        check_val("mid_err2", err, 1'b0);
        rst_n = 1'b1;
        run_instr(4'd0, 4'd1, 4'd2, 8'h00, 1'b0, 0, 4'd0, 16'h0, 1'b0, 16'h0000, 16'h0000);
        check_rf("post_rf1", 4'd1, 16'h0000);
        check_val("post_psr", psr, 5'h08);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter PSR_RST, default 5'b00000, giving the PSR reset value; bit map C=0, L=1, F=2, Z=3, N=4.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port instr_valid, input, 1, instruction offered.
REQ-005 SHALL have port instr_ready, output, 1, sequencer can accept an instruction.
REQ-006 SHALL have ports instr_op (input, 4, ALU opcode), instr_rdest (input, 4, destination/first operand register) and instr_rsrc (input, 4, source register).
REQ-007 SHALL have ports instr_imm (input, 8, immediate) and instr_imm_sel (input, 1, use immediate as Rsrc); both are ignored unless ALU_SEQ_IMM_EN is defined.
REQ-008 SHALL have ports alu_rsrc (output, 16), alu_rdest (output, 16) and alu_opcode (output, 4), which drive the ALU.
REQ-009 SHALL have ports alu_out (input, 16) and alu_flags (input, 5), which are the ALU results.
REQ-010 SHALL have ports rf_wr_en (input, 1), rf_wr_addr (input, 4) and rf_wr_data (input, 16), the host register-file write port.
REQ-011 SHALL have ports rf_rd_addr (input, 4, host read address) and rf_rd_data (output, 16, combinational read of rf[rf_rd_addr]).
REQ-012 SHALL have ports done (output, 1, one-cycle completion pulse), err (output, 1, one-cycle illegal-opcode pulse), psr (output, 5, flag register) and wb_data (output, 16, last captured alu_out).

Function
REQ-013 SHALL contain a 16-entry x 16-bit register file rf.
REQ-014 SHALL implement four states, IDLE, READ, EXEC and WB, with these transitions: IDLE->READ on instr_valid&&instr_ready; READ->EXEC; EXEC->WB; WB->IDLE, all unconditional except the first.
REQ-015 SHALL assert instr_ready only in IDLE; on acceptance, latch op, rdest, rsrc, imm and imm_sel.
REQ-016 SHALL, in READ, register operand A=rf[rdest] and operand B=rf[rsrc], using values present before that clock edge.
REQ-017 SHALL drive alu_rdest=A, alu_rsrc=B and alu_opcode=latched op from registers, stable from EXEC through WB; they hold their values in IDLE.
REQ-018 SHALL, at the end of EXEC, capture alu_out into wb_data and alu_flags into an internal flag register.
REQ-019 SHALL, in WB, for op 0,1,3-9, write rf[rdest] with wb_data.
REQ-020 SHALL, in WB, for op 2 (CMP), perform no register write.
REQ-021 SHALL update psr at the WB edge: for op 0-1, all 5 bits; for op 2, L, Z and N only, with C and F retained; for op 3-9, psr unchanged.
REQ-022 SHALL treat op 10-15 as illegal: the instruction traverses all states, err pulses with done in WB, there is no rf write, and psr is unchanged.
REQ-023 SHALL assert done high for exactly the WB cycle, 3 cycles after the accept edge; throughput is one instruction per 4 cycles.
REQ-024 SHALL give the sequencer writeback priority when a host write and a WB write target the same address in the same cycle; a host write to a different address in WB also completes.
REQ-025 SHALL make host writes in READ to rdest/rsrc invisible to the current instruction.
REQ-026 SHALL ignore instr_valid outside IDLE; instruction fields may change freely while ready is low.

Reset
REQ-027 SHALL, on rst_n low, immediately and asynchronously set state=IDLE, all rf entries=0, psr=PSR_RST, wb_data=0, alu_rsrc/alu_rdest=0, alu_opcode=0, and done=err=0; instr_ready is 1 during reset.
REQ-028 SHALL abandon any in-flight instruction when reset is asserted mid-operation, with no write, no done and no err; the first accept is possible on the first clk edge after rst_n rises.

Configuration
REQ-029 SHALL, with macro ALU_SEQ_IMM_EN defined and instr_imm_sel=1, latch operand B as the sign-extended instr_imm in READ instead of rf[rsrc].
REQ-030 SHALL, without ALU_SEQ_IMM_EN, omit immediate logic, always source B from rf[rsrc], and ignore instr_imm and instr_imm_sel.

Verification
REQ-031 SHALL cover ADD: host writes rf[1]=0x0005 and rf[2]=0x0003, then op=0 with rdest=1 and rsrc=2 -> done 3 cycles after accept, rf[1]=0x0008, psr.C=0, psr.Z=0.
REQ-032 SHALL cover SUB: rf[1]=0x0003, rf[2]=0x0005, op=1 -> rf[1]=0xFFFE, psr.L=1, psr.N=1, psr.C=0.
REQ-033 SHALL cover CMP after an ADD that set C=1: rf[3]=rf[4]=0x1234, op=2 -> psr.Z=1, psr.C still 1, rf[3]=0x1234.
REQ-034 SHALL cover an illegal opcode: op=4'hC -> err and done high together for one cycle, rf and psr unchanged.
REQ-035 SHALL cover reset mid-operation: rst_n low during EXEC -> outputs zero with no clk edge required, no done, and instr_ready=1 after release.
REQ-036 SHALL cover immediates with ALU_SEQ_IMM_EN defined: rf[1]=0x0010, imm=0xFE, imm_sel=1, op=0 -> rf[1]=0x000E, psr.C=1.
